// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath width, opcode
// encodings and the ALU result payload.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_CMPU = 3'd4,
        OP_CMPS = 3'd5,
        OP_SLL  = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              err;
    } alu_res_t;

endpackage

// File: rtl/alu_arbiter_alu32.sv
// Combinational 32-bit ALU shared by both arbiter ports.
module alu_arbiter_alu32
    import alu_arbiter_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output alu_res_t          res_c
);

    logic [DATA_W-1:0] result;
    logic              err;

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_CMPU: result = DATA_W'(a < b);
            OP_CMPS: result = DATA_W'($signed(a) < $signed(b));
            OP_SLL:  result = b << a[SHAMT_W-1:0];
            OP_RSVD: err    = 1'b1;
            default: err    = 1'b1;
        endcase
    end

    assign res_c = '{result: result, zero: (result == '0), err: err};

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one ALU; each port owns a one-entry
// response buffer that may be reloaded on the same edge it drains.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result0,
    output logic [WIDTH-1:0] resp_result1,
    output logic [1:0]       resp_zero,
    output logic [1:0]       resp_err
);

    logic [1:0]        eligible;
    logic [1:0]        hs;
    logic              sel;
    logic              last_grant;
    logic [1:0]        valid_q;
    alu_res_t          buf_q [2];
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    alu_res_t          alu_res;

    // Grant depends only on handshake state and the pointer, never on payload.
    always_comb begin
        eligible  = req_valid & (~valid_q | resp_ready);
        req_ready = 2'b00;
        if (!reset) begin
            if (eligible == 2'b11) begin
                req_ready = last_grant ? 2'b01 : 2'b10;
            end else begin
                req_ready = eligible;
            end
        end
        hs  = req_valid & req_ready;
        sel = req_ready[1];
    end

    always_comb begin
        alu_op = sel ? alu_op_e'(req_op1) : alu_op_e'(req_op0);
        alu_a  = sel ? req_a1 : req_a0;
        alu_b  = sel ? req_b1 : req_b0;
    end

    alu_arbiter_alu32 u_alu32 (
        .op    (alu_op),
        .a     (alu_a),
        .b     (alu_b),
        .res_c (alu_res)
    );

    // last_grant = 1 means port 1 was granted most recently.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            valid_q    <= 2'b00;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            if (|hs) begin
                last_grant <= sel;
            end
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    valid_q[i] <= 1'b1;
                    buf_q[i]   <= alu_res;
                end else if (resp_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign resp_valid   = valid_q;
    assign resp_result0 = buf_q[0].result;
    assign resp_result1 = buf_q[1].result;
    assign resp_zero    = {buf_q[1].zero, buf_q[0].zero};
    assign resp_err     = {buf_q[1].err, buf_q[0].err};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-port opcode table, then round-robin,
// back-pressure and reset sequences.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result0, resp_result1;
    logic [1:0]  resp_zero;
    logic [1:0]  resp_err;

    int vecs;
    int errs;

    alu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result0 (resp_result0),
        .resp_result1 (resp_result1),
        .resp_zero    (resp_zero),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_op0 = 3'd0; req_a0 = 32'd0; req_b0 = 32'd0;
        req_op1 = 3'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    endtask

    task automatic drive(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        tbl[0]  = '{0, 3'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        tbl[1]  = '{0, 3'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0};
        tbl[2]  = '{1, 3'd2, 32'hF0F0_FFFF,  32'h0FF0_00FF,  32'h00F0_00FF,  1'b0, 1'b0};
        tbl[3]  = '{1, 3'd3, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 1'b0};
        tbl[4]  = '{0, 3'd5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        tbl[5]  = '{0, 3'd4, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        tbl[6]  = '{1, 3'd6, 32'd4,          32'd1,          32'd16,         1'b0, 1'b0};
        tbl[7]  = '{0, 3'd7, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1};
        tbl[8]  = '{1, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        tbl[9]  = '{1, 3'd6, 32'h0000_0023,  32'd1,          32'd8,          1'b0, 1'b0};
        tbl[10] = '{0, 3'd4, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};

        // Reset state, with requests pending to show nothing is accepted.
        reset = 1'b1;
        idle();
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_result0", resp_result0, 32'd0);
        chk("reset_result1", resp_result1, 32'd0);
        chk("reset_zero_err", 32'({resp_zero, resp_err}), 32'd0);
        reset = 1'b0;
        idle();

        // Single-port opcode table.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            drive(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(1 << tbl[i].port));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(1 << tbl[i].port));
            chk($sformatf("v%0d_result", i),
                (tbl[i].port == 0) ? resp_result0 : resp_result1, tbl[i].res);
            chk($sformatf("v%0d_zero", i), 32'(resp_zero[tbl[i].port]), 32'(tbl[i].zero));
            chk($sformatf("v%0d_err", i), 32'(resp_err[tbl[i].port]), 32'(tbl[i].err));
        end
        @(negedge clk);
        idle();

        // Round robin with both ports requesting every cycle.
        do_reset();
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive(0, 3'd1, 32'd3, 32'd3);
            drive(1, 3'd1, 32'd3, 32'd3);
            #1;
            chk($sformatf("rr%0d_req_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rr%0d_resp_valid", k), 32'(resp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_result", k), (k % 2 == 0) ? resp_result0 : resp_result1, 32'd0);
            chk($sformatf("rr%0d_zero", k), 32'(resp_zero[k % 2]), 32'd1);
        end
        idle();

        // Back-pressure on port 1 while port 0 streams.
        do_reset();
        resp_ready = 2'b01;
        drive(1, 3'd0, 32'd2, 32'd3);
        #1;
        chk("bp_fill_req_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("bp_fill_resp_valid", 32'(resp_valid), 32'd2);
        chk("bp_fill_result1", resp_result1, 32'd5);
        for (int k = 0; k < 3; k++) begin
            drive(0, 3'd0, 32'(k), 32'd100);
            drive(1, 3'd0, 32'd10, 32'd20);
            #1;
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd3);
            chk($sformatf("bp%0d_result0", k), resp_result0, 32'(k + 100));
            chk($sformatf("bp%0d_result1_held", k), resp_result1, 32'd5);
        end
        req_valid[0] = 1'b0;
        resp_ready = 2'b11;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_resp_valid", 32'(resp_valid), 32'd2);
        chk("bp_release_result1", resp_result1, 32'd30);
        idle();

        // Reset right after a handshake discards the response and restores priority.
        do_reset();
        drive(0, 3'd0, 32'd1, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_resp_valid", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        drive(1, 3'd0, 32'd4, 32'd4);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_result0", resp_result0, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_tie_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_tie_resp_valid", 32'(resp_valid), 32'd1);
        chk("rst_tie_result0", resp_result0, 32'd2);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
